// File: rtl/ckdiv_glitchfree.sv
// Programmable integer clock divider feeding the glitch-free clock mux.
// Ratio changes and start/stop are applied only at period boundaries; clk_out comes from a flop.
module ckdiv_glitchfree #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic             div_load,
  output logic             div_busy,
  output logic [WIDTH-1:0] cur_ratio,
  output logic             clk_out,
  output logic             period_tick
);

  localparam logic [WIDTH-1:0] DefaultDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MinDiv     = WIDTH'(2);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] cur_d;
  logic             busy_d;
  logic             clk_out_d;
  logic             tick_d;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] n_eff;
  logic [WIDTH-1:0] half_eff;
  logic             wrap;
  logic             apply;

  always_comb begin
    load_val = (div_ratio < MinDiv) ? MinDiv : div_ratio;
    wrap     = (state_q == StRun) && (cnt_q == cur_ratio - WIDTH'(1));
    // A pending ratio lands on any idle edge or on the wrap edge of a running period.
    apply    = div_busy && ((state_q == StIdle) || wrap);
    n_eff    = apply ? pend_q : cur_ratio;
    half_eff = n_eff >> 1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    cur_d     = cur_ratio;
    busy_d    = div_busy;
    clk_out_d = clk_out;
    tick_d    = 1'b0;

    if (apply) begin
      cur_d  = pend_q;
      busy_d = 1'b0;
    end
    // A load on the applying edge becomes pending for the following boundary.
    if (div_load) begin
      pend_d = load_val;
      busy_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (en) begin
          state_d   = StRun;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
        end
      end
      StRun: begin
        if (wrap) begin
          cnt_d = '0;
          if (!en) begin
            state_d   = StIdle;
            clk_out_d = 1'b0;
            tick_d    = 1'b0;
          end else begin
            clk_out_d = (cnt_d < half_eff);
            tick_d    = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q + WIDTH'(1);
          clk_out_d = (cnt_d < half_eff);
          tick_d    = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_q      <= '0;
      cur_ratio   <= DefaultDiv;
      div_busy    <= 1'b0;
      clk_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      cur_ratio   <= cur_d;
      div_busy    <= busy_d;
      clk_out     <= clk_out_d;
      period_tick <= tick_d;
    end
  end

endmodule

// File: doc/ckdiv_glitchfree.md
Name: ckdiv_glitchfree

Overview:
- Programmable integer clock divider that generates the slow clock fed into the glitch-free clock mux as one of its two source clocks.
- Divided output is taken directly from a flop, so it is glitch-free.
- Divide ratio changes only at a period boundary, so no runt high or low phase ever reaches the mux.
- Start/stop is also period-aligned, so the output never truncates a phase.

Parameters:
- WIDTH, 8, width of the divide-ratio field and of the phase counter.
- DEFAULT_DIV, 4, divide ratio active after reset (must be >=2 and <2^WIDTH).

Ports:
- clk  input  1  source clock; all flops on posedge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  run request; level-sensitive.
- div_ratio  input  WIDTH  requested divide ratio N; sampled when div_load=1.
- div_load  input  1  single-cycle strobe that captures div_ratio into the pending register.
- div_busy  output  1  high while a captured ratio is pending and not yet applied.
- cur_ratio  output  WIDTH  ratio currently in effect.
- clk_out  output  1  divided clock; registered output.
- period_tick  output  1  one-cycle pulse at each period start of clk_out.

Behaviour:
- Reset values (async assert, sync to clk on deassert edge not required):
  - state=IDLE, cnt=0, clk_out=0, period_tick=0.
  - div_busy=0, cur_ratio=DEFAULT_DIV, pending register=0.
- Ratio clamp: any captured value <2 (0 or 1) is stored as 2. Maximum ratio is 2^WIDTH-1.
- Output waveform for ratio N:
  - Period is N clk cycles.
  - clk_out is high for floor(N/2) cycles, then low for N-floor(N/2) cycles.
  - Examples: N=3 gives 1 high, 2 low; N=4 gives 2 high, 2 low.
- State IDLE:
  - cnt=0, clk_out=0.
  - If en=1 at a posedge: go to RUN; same edge sets cnt_next=0, clk_out<=1, period_tick<=1.
  - First high phase begins 1 cycle after en is sampled.
- State RUN, each posedge:
  - cnt_next = (cnt==N-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next < floor(N/2)).
  - period_tick <= (cnt_next==0).
- Stopping:
  - en is only examined in RUN at the wrap edge (cnt==N-1).
  - If en=0 at that edge: go to IDLE, clk_out<=0, period_tick<=0.
  - Deasserting en mid-period therefore completes the current period.
  - A glitch of en that falls and rises again before the wrap edge has no effect.
- Ratio change:
  - div_load=1 captures the clamped div_ratio into pending; div_busy<=1 on the same edge.
  - In RUN, pending is applied at the next wrap edge. cur_ratio<=pending and div_busy<=0 at that edge, and the new period's clk_out/cnt are computed with the new N.
  - In IDLE, pending is applied on the edge after capture; div_busy is high for exactly 1 cycle.
  - A load while div_busy=1 overwrites pending; only the last value is applied, at one boundary.
  - A load on the wrap edge itself: the old pending (if any) is applied at this edge; the new value becomes pending for the following boundary.
  - A load on the same edge RUN->IDLE: the value becomes pending and is applied on the next IDLE edge.
- cur_ratio never changes mid-period. clk_out high and low phases are never shorter than the floor(N/2) / N-floor(N/2) lengths of the active N.
- Reset mid-operation: immediate return to reset values; any pending ratio is discarded.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=4 -> clk_out pattern 1100 repeating from the cycle after en; period_tick every 4th cycle; cur_ratio=4; div_busy=0.
- Running at N=4, div_load with div_ratio=7 at cnt=1 -> div_busy high until the next wrap; current period stays 1100; then 1110000 repeating; cur_ratio=7 from the wrap edge.
- div_ratio=0 and div_ratio=1 loads -> cur_ratio=2, clk_out toggles 10 repeating; div_ratio=255 (WIDTH=8) -> 127 high, 128 low.
- Two loads (5 then 9) within one period at N=6 -> only 9 is applied, at one boundary; no period of length 5 appears; div_busy stays high continuously until applied.
- en dropped at cnt=0 of an N=6 period -> full 111000 period completes, then clk_out=0 and state IDLE; re-assert en -> restarts with high phase, period_tick pulses.
- rst asserted asynchronously mid-high-phase with a pending load -> clk_out=0 immediately; cur_ratio=DEFAULT_DIV and div_busy=0 after release.
